// File: rtl/demux_pkg.sv
// ----------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the registered 1-to-2 stream demultiplexer.
//   BR0 / BR1        : select values for branch 0 and branch 1
//   branch_state_e   : per-branch holding-register state (EMPTY / FULL)
// Optional feature macro used by the design files: DEMUX_COUNT_EN
// ----------------------------------------------------------------------------
package demux_pkg;

  localparam logic BR0 = 1'b0;
  localparam logic BR1 = 1'b1;

  // The state bit doubles as the branch Valid output.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } branch_state_e;

endpackage : demux_pkg

// File: rtl/demux_branch_reg.sv
// ----------------------------------------------------------------------------
// demux_branch_reg
// One output branch of the stream demultiplexer: a one-entry holding register
// with its EMPTY/FULL state, the branch ready equation and an optional
// drain-handshake counter (enabled by macro DEMUX_COUNT_EN).
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   Load       in   write Load_Data into the holding register this cycle
//   Load_Data  in   WIDTH  word to capture
//   Valid      out  holding register full (state bit)
//   Ready      in   downstream consumer accepts
//   Data       out  WIDTH  held word
//   Rdy        out  branch can take a new word this cycle
//   Cnt        out  CNT_W  completed drain handshakes (0 when feature disabled)
// ----------------------------------------------------------------------------
module demux_branch_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Load,
  input  logic [WIDTH-1:0] Load_Data,
  output logic             Valid,
  input  logic             Ready,
  output logic [WIDTH-1:0] Data,
  output logic             Rdy,
  output logic [CNT_W-1:0] Cnt
);

  branch_state_e    r_state;
  branch_state_e    w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic             w_drain;

  // State register and holding register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (Load) begin
        r_data <= Load_Data;
      end
    end
  end

  // Next-state logic. A load wins over a drain so that a same-cycle
  // drain+load keeps the branch FULL with the new word.
  always_comb begin
    w_state_nxt = r_state;
    w_drain     = (r_state == ST_FULL) && Ready;
    if (Load) begin
      w_state_nxt = ST_FULL;
    end else if (w_drain) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  // Ready when there is room, or when the current word leaves this cycle.
  assign Rdy   = (r_state == ST_EMPTY) || Ready;
  assign Valid = (r_state == ST_FULL);
  assign Data  = r_data;

`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Counts output handshakes only; wraps naturally at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_drain) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign Cnt = r_cnt;
`else
  assign Cnt = '0;
`endif

endmodule : demux_branch_reg

// File: rtl/demux_1to2_stream.sv
// ----------------------------------------------------------------------------
// demux_1to2_stream
// Registered 1-to-2 demultiplexer for a valid/ready stream. Each input word is
// routed by In_Sel into one of two independent one-entry branch registers, so
// a stalled consumer on one branch never disturbs the other branch.
// Optional per-branch handshake counters: macro DEMUX_COUNT_EN.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   synchronous active-low reset
//   In_Valid    in   upstream word valid
//   In_Ready    out  selected branch can take the word (no path from In_Valid)
//   In_Sel      in   0 -> Out0, 1 -> Out1; stable while In_Valid=1
//   In_Data     in   WIDTH  upstream word
//   Out0_Valid  out  branch-0 register full
//   Out0_Ready  in   branch-0 consumer accepts
//   Out0_Data   out  WIDTH  branch-0 word
//   Out1_Valid  out  branch-1 register full
//   Out1_Ready  in   branch-1 consumer accepts
//   Out1_Data   out  WIDTH  branch-1 word
//   Cnt0        out  CNT_W  branch-0 drain handshakes (0 when disabled)
//   Cnt1        out  CNT_W  branch-1 drain handshakes (0 when disabled)
// ----------------------------------------------------------------------------
module demux_1to2_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic             In_Sel,
  input  logic [WIDTH-1:0] In_Data,
  output logic             Out0_Valid,
  input  logic             Out0_Ready,
  output logic [WIDTH-1:0] Out0_Data,
  output logic             Out1_Valid,
  input  logic             Out1_Ready,
  output logic [WIDTH-1:0] Out1_Data,
  output logic [CNT_W-1:0] Cnt0,
  output logic [CNT_W-1:0] Cnt1
);

  logic w_rdy0;
  logic w_rdy1;
  logic w_accept;
  logic w_load0;
  logic w_load1;

  // In_Ready depends only on select and branch state/ready, never In_Valid.
  assign In_Ready = (In_Sel == BR1) ? w_rdy1 : w_rdy0;
  assign w_accept = In_Valid && In_Ready;

  // Exactly one branch is loaded per accepted word.
  assign w_load0  = w_accept && (In_Sel == BR0);
  assign w_load1  = w_accept && (In_Sel == BR1);

  demux_branch_reg #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_br0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .Load      (w_load0),
    .Load_Data (In_Data),
    .Valid     (Out0_Valid),
    .Ready     (Out0_Ready),
    .Data      (Out0_Data),
    .Rdy       (w_rdy0),
    .Cnt       (Cnt0)
  );

  demux_branch_reg #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_br1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .Load      (w_load1),
    .Load_Data (In_Data),
    .Valid     (Out1_Valid),
    .Ready     (Out1_Ready),
    .Data      (Out1_Data),
    .Rdy       (w_rdy1),
    .Cnt       (Cnt1)
  );

endmodule : demux_1to2_stream

// File: tb/tb_demux_1to2_stream.sv
module tb_demux_1to2_stream;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             In_Valid;
  logic             In_Ready;
  logic             In_Sel;
  logic [WIDTH-1:0] In_Data;
  logic             Out0_Valid, Out1_Valid;
  logic             Out0_Ready, Out1_Ready;
  logic [WIDTH-1:0] Out0_Data, Out1_Data;
  logic [CNT_W-1:0] Cnt0, Cnt1;

  always #5 clk = ~clk;

  demux_1to2_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .In_Sel     (In_Sel),
    .In_Data    (In_Data),
    .Out0_Valid (Out0_Valid),
    .Out0_Ready (Out0_Ready),
    .Out0_Data  (Out0_Data),
    .Out1_Valid (Out1_Valid),
    .Out1_Ready (Out1_Ready),
    .Out1_Data  (Out1_Data),
    .Cnt0       (Cnt0),
    .Cnt1       (Cnt1)
  );

  // Reference model: each branch is a queue holding at most one word, the
  // last word ever written to it, and a count of words taken by the consumer.
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic [WIDTH-1:0] last0, last1;
  int unsigned      cnt0, cnt1;
  bit               model_known;
  bit               last_accept;

  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_cnt(input int unsigned c);
`ifdef DEMUX_COUNT_EN
    return 64'(c % (1 << CNT_W));
`else
    return 64'(0 * c);
`endif
  endfunction

  // One clock: drive inputs after the falling edge, check outputs against the
  // model, then advance the model by what the rising edge will do.
  task automatic cyc(input logic v, input logic s, input logic [WIDTH-1:0] d,
                     input logic r0, input logic r1, input logic rn);
    bit room0, room1, acc;
    @(negedge clk);
    In_Valid = v; In_Sel = s; In_Data = d;
    Out0_Ready = r0; Out1_Ready = r1; rst_n = rn;
    #1;
    room0 = (q0.size() == 0) || r0;
    room1 = (q1.size() == 0) || r1;
    if (model_known) begin
      chk("out0_valid", 64'(Out0_Valid), 64'(q0.size() != 0));
      chk("out1_valid", 64'(Out1_Valid), 64'(q1.size() != 0));
      chk("out0_data", 64'(Out0_Data), 64'(last0));
      chk("out1_data", 64'(Out1_Data), 64'(last1));
      chk("in_ready", 64'(In_Ready), 64'(s ? room1 : room0));
      chk("cnt0", 64'(Cnt0), exp_cnt(cnt0));
      chk("cnt1", 64'(Cnt1), exp_cnt(cnt1));
    end
    acc = 1'b0;
    if (!rn) begin
      q0.delete(); q1.delete();
      last0 = '0; last1 = '0;
      cnt0 = 0; cnt1 = 0;
      model_known = 1'b1;
    end else if (model_known) begin
      acc = v && (s ? room1 : room0);
      if (q0.size() != 0 && r0) begin void'(q0.pop_front()); cnt0++; end
      if (q1.size() != 0 && r1) begin void'(q1.pop_front()); cnt1++; end
      if (acc && !s) begin q0.push_back(d); last0 = d; end
      if (acc && s)  begin q1.push_back(d); last1 = d; end
    end
    last_accept = acc;
  endtask

  logic             hv, hs;
  logic [WIDTH-1:0] hd;

  initial begin
    n_vec = 0; n_err = 0;
    model_known = 1'b0;
    last0 = '0; last1 = '0; cnt0 = 0; cnt1 = 0;
    rst_n = 1'b0; In_Valid = 1'b0; In_Sel = 1'b0; In_Data = '0;
    Out0_Ready = 1'b0; Out1_Ready = 1'b0;

    // Reset held two cycles with a valid word present: nothing is loaded.
    cyc(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Back-to-back streaming into branch 0.
    cyc(1'b1, 1'b0, 32'h11, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 32'h22, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 32'h33, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

    // Stall isolation: branch 1 holds 0xAA, 0xBB stalls, 0xCC goes to branch 0.
    cyc(1'b1, 1'b1, 32'hAA, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 32'hBB, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 32'hBB, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 32'hCC, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

    // Simultaneous drain and load of branch 0.
    cyc(1'b1, 1'b0, 32'h01, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 32'h02, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Reset while both branches are full.
    cyc(1'b1, 1'b1, 32'h5A5A_0001, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // 17 branch-0 handshakes: counter wraps at CNT_W=4.
    for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0, 32'(i + 100), 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic; a stalled word keeps its select and data.
    hv = 1'b0; hs = 1'b0; hd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!(hv && !last_accept)) begin
        hv = ($urandom_range(0, 3) != 0);
        hs = 1'($urandom_range(0, 1));
        hd = $urandom;
      end
      cyc(hv, hs, hd, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 49) != 0));
      if (!rst_n) hv = 1'b0;
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_demux_1to2_stream

// File: doc/demux_1to2_stream.md
Name: demux_1to2_stream

Overview:
- Registered 1-to-2 demultiplexer for a valid/ready stream. It is the inverse of the 2-to-1 select path.
- A single producer word plus a 1-bit select is routed to one of two consumer ports.
- Each output branch has its own one-entry holding register, so one stalled consumer never corrupts the other branch's data.
- Sits between a result source and two sinks, e.g. writeback to the register file vs. to the memory stage.

Parameters:
- WIDTH, 32, data bus width in bits.
- CNT_W, 16, width of the optional per-branch transfer counters.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low (one clock; reset is synchronous and active-low).
- In_Valid  input  1  upstream word valid.
- In_Ready  output  1  block can accept the word on the selected branch this cycle.
- In_Sel  input  1  branch select: 0 -> Out0, 1 -> Out1; must be stable while In_Valid=1.
- In_Data  input  WIDTH  upstream word.
- Out0_Valid  output  1  branch-0 holding register full.
- Out0_Ready  input  1  branch-0 consumer accepts.
- Out0_Data  output  WIDTH  branch-0 word.
- Out1_Valid  output  1  branch-1 holding register full.
- Out1_Ready  input  1  branch-1 consumer accepts.
- Out1_Data  output  WIDTH  branch-1 word.
- Cnt0  output  CNT_W  completed branch-0 output handshakes (optional feature).
- Cnt1  output  CNT_W  completed branch-1 output handshakes (optional feature).

Behaviour:
- Per-branch FSM, 2 states: EMPTY (Valid=0) and FULL (Valid=1). Out*_Valid is the state bit.
- Reset (rst_n=0 at rising edge):
  - both branches go to EMPTY.
  - Out0_Data, Out1_Data, Cnt0, Cnt1 all go to 0.
  - A reset mid-transfer discards any held words with no output handshake.
- Branch b ready: rdy_b = (state_b==EMPTY) | Outb_Ready.
- In_Ready = rdy[In_Sel]. This is combinational from In_Sel, Out*_Ready and state; no path from In_Valid.
- Accept = In_Valid & In_Ready.
  - On accept, In_Data is loaded into branch In_Sel and that branch goes FULL next cycle.
  - Latency: exactly 1 cycle from accept to Out*_Valid=1.
- Branch b drain = Outb_Valid & Outb_Ready.
  - Drain with no load: FULL -> EMPTY.
  - Drain and load of the same branch in the same cycle: stays FULL with the new word (full throughput, 1 word/cycle).
- FULL and not ready:
  - Outb_Data is held stable; Valid is never deasserted without a handshake.
  - A word selecting that branch sees In_Ready=0 and stalls.
  - The other branch is unaffected.
- Only one branch is loaded per cycle. Both branches may drain in the same cycle.
- Ordering is preserved within a branch. No ordering guarantee across branches.
- Out*_Data holds its last value after a drain; the value is don't-care while Valid=0.

Optional Feature:
- Macro: DEMUX_COUNT_EN.
- Defined:
  - Cntb increments by 1 on each branch-b drain handshake.
  - Wraps modulo 2^CNT_W (all-ones -> 0).
  - Cleared by reset.
- Undefined: Cnt0 and Cnt1 are tied to 0 and no counter flops are inferred. The ports remain, so the interface is identical either way.

Decomposition:
- Shared package demux_pkg:
  - localparams BR0=1'b0, BR1=1'b1.
  - branch state encoding ST_EMPTY=1'b0, ST_FULL=1'b1.
- Sub-module demux_branch_reg, instantiated twice. It contains:
  - the holding register, state bit and ready equation;
  - the optional counter.
  - Ports: clk, rst_n, Load, Load_Data, Valid, Ready, Data, Rdy, Cnt.
- Top level contains select decode and In_Ready mux only.

Test Plan:
- Reset: hold rst_n=0 two cycles with In_Valid=1 -> Out0_Valid=Out1_Valid=0, data/counters 0, no load occurs.
- Streaming branch 0: In_Sel=0, words 0x11,0x22,0x33 back-to-back, Out0_Ready=1 -> Out0_Data 0x11,0x22,0x33 on consecutive cycles starting 1 cycle after first accept; In_Ready=1 throughout; Out1_Valid=0.
- Stall isolation: branch 1 FULL with 0xAA, Out1_Ready=0; send In_Sel=1 word 0xBB -> In_Ready=0, Out1_Data stays 0xAA; then send In_Sel=0 word 0xCC -> accepted, Out0 delivers 0xCC while branch 1 still holds 0xAA.
- Simultaneous drain+load: branch 0 FULL 0x01, Out0_Ready=1, In_Sel=0 In_Data=0x02 same cycle -> In_Ready=1, next cycle Out0_Valid=1, Out0_Data=0x02.
- Reset mid-operation: both branches FULL, assert rst_n=0 for 1 cycle -> both Valid=0 next cycle, Cnt0/Cnt1 unchanged by the discarded words (0).
- DEMUX_COUNT_EN wrap: CNT_W=4, drive 17 branch-0 handshakes -> Cnt0=1, Cnt1=0; build without the macro -> Cnt0=Cnt1=0 always.
